// File: rtl/mic_spi_sampler.sv
// -----------------------------------------------------------------------------
// mic_spi_sampler
//   Serial front end for the Pmod MIC3 (ADCS7476-style converter). A free-running
//   tick counter paces the frames. On each tick with enable high, one 16-bit
//   frame is read MSB first: 4 leading zeros followed by 12 data bits. The low
//   12 bits are presented on 'sample' together with a one-cycle 'sample_valid'
//   strobe.
//
// Ports
//   clock         in   system clock (100 MHz)
//   reset         in   asynchronous, active-high
//   enable        in   allows a new frame to start at the next tick
//   J_MIC_Pin3    in   MISO from the converter
//   J_MIC_Pin1    out  chip select, active-low
//   J_MIC_Pin4    out  serial clock, idles high
//   sample        out  last captured sample (mid-scale after reset)
//   sample_valid  out  one-cycle strobe, new value on sample
//   busy          out  high while a frame is in progress
//   frame_err     out  leading bits of the last frame were not all zero
// -----------------------------------------------------------------------------
module mic_spi_sampler #(
    parameter int SAMPLE_DIV = 5000,
    parameter int SCLK_HALF  = 25,
    parameter int FRAME_BITS = 16,
    parameter int DATA_BITS  = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 J_MIC_Pin3,
    output logic                 J_MIC_Pin1,
    output logic                 J_MIC_Pin4,
    output logic [DATA_BITS-1:0] sample,
    output logic                 sample_valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam int BW = $clog2(FRAME_BITS + 1);

    localparam logic [TW-1:0]        TICK_MAX  = TW'(SAMPLE_DIV - 1);
    localparam logic [HW-1:0]        HALF_MAX  = HW'(SCLK_HALF - 1);
    localparam logic [BW-1:0]        BITS_LAST = BW'(FRAME_BITS);
    localparam logic [DATA_BITS-1:0] MID_SCALE = {1'b1, {(DATA_BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CS_SETUP = 3'd1,
        S_SHIFT    = 3'd2,
        S_CS_HOLD  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                r_state;
    logic [TW-1:0]         r_tick_cnt;
    logic [HW-1:0]         r_half_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shreg;
    logic                  r_sclk;
    logic                  r_cs;
    logic [DATA_BITS-1:0]  r_sample;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_frame_err;

    state_t                w_state_nxt;
    logic [HW-1:0]         w_half_nxt;
    logic [BW-1:0]         w_bit_nxt;
    logic [FRAME_BITS-1:0] w_shreg_nxt;
    logic                  w_sclk_nxt;
    logic [DATA_BITS-1:0]  w_sample_nxt;
    logic                  w_ferr_nxt;
    logic                  w_tick;
    logic                  w_half_end;

    assign w_tick     = (r_tick_cnt == TICK_MAX);
    assign w_half_end = (r_half_cnt == HALF_MAX);

    assign J_MIC_Pin1   = r_cs;
    assign J_MIC_Pin4   = r_sclk;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign busy         = r_busy;
    assign frame_err    = r_frame_err;

    // Free-running sample tick counter, independent of enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= {TW{1'b0}};
        end else if (w_tick) begin
            r_tick_cnt <= {TW{1'b0}};
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Frame sequencer: next state plus next values of every frame register.
    always_comb begin
        w_state_nxt  = r_state;
        w_half_nxt   = r_half_cnt;
        w_bit_nxt    = r_bit_cnt;
        w_shreg_nxt  = r_shreg;
        w_sclk_nxt   = r_sclk;
        w_sample_nxt = r_sample;
        w_ferr_nxt   = r_frame_err;
        case (r_state)
            S_IDLE: begin
                w_half_nxt = {HW{1'b0}};
                w_bit_nxt  = {BW{1'b0}};
                w_sclk_nxt = 1'b1;
                if (w_tick && enable) begin
                    w_state_nxt = S_CS_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CS_SETUP: begin
                if (w_half_end) begin
                    // First serial clock edge of the frame is a falling one.
                    w_half_nxt  = {HW{1'b0}};
                    w_sclk_nxt  = 1'b0;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_half_nxt = r_half_cnt + HW'(1);
                end
            end
            S_SHIFT: begin
                if (w_half_end) begin
                    w_half_nxt = {HW{1'b0}};
                    if (!r_sclk) begin
                        // Rising edge: converter data has been stable for a full low phase.
                        w_sclk_nxt  = 1'b1;
                        w_shreg_nxt = {r_shreg[FRAME_BITS-2:0], J_MIC_Pin3};
                        w_bit_nxt   = r_bit_cnt + BW'(1);
                    end else if (r_bit_cnt == BITS_LAST) begin
                        // Last high phase done: leave sclk parked high.
                        w_state_nxt = S_CS_HOLD;
                    end else begin
                        w_sclk_nxt = 1'b0;
                    end
                end else begin
                    w_half_nxt = r_half_cnt + HW'(1);
                end
            end
            S_CS_HOLD: begin
                if (w_half_end) begin
                    // Result is loaded on entry to DONE so it appears with the strobe.
                    w_half_nxt   = {HW{1'b0}};
                    w_state_nxt  = S_DONE;
                    w_sample_nxt = r_shreg[DATA_BITS-1:0];
                    w_ferr_nxt   = |r_shreg[FRAME_BITS-1:DATA_BITS];
                end else begin
                    w_half_nxt = r_half_cnt + HW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sclk_nxt  = 1'b1;
            end
        endcase
    end

    // Frame registers; pin/status outputs decoded from the next state so they stay registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_half_cnt  <= {HW{1'b0}};
            r_bit_cnt   <= {BW{1'b0}};
            r_shreg     <= {FRAME_BITS{1'b0}};
            r_sclk      <= 1'b1;
            r_cs        <= 1'b1;
            r_sample    <= MID_SCALE;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_half_cnt  <= w_half_nxt;
            r_bit_cnt   <= w_bit_nxt;
            r_shreg     <= w_shreg_nxt;
            r_sclk      <= w_sclk_nxt;
            r_cs        <= !((w_state_nxt == S_CS_SETUP) || (w_state_nxt == S_SHIFT));
            r_sample    <= w_sample_nxt;
            r_valid     <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_frame_err <= w_ferr_nxt;
        end
    end

    mic_spi_sampler_chk u_chk (
        .i_clock (clock),
        .i_reset (reset),
        .i_tick  (w_tick),
        .i_busy  (r_busy)
    );

endmodule

// -----------------------------------------------------------------------------
// mic_spi_sampler_chk
//   Flags a sample tick that arrives while a frame is still in progress, which
//   means SAMPLE_DIV is too small for the frame length.
// Ports
//   i_clock  in  system clock
//   i_reset  in  asynchronous, active-high
//   i_tick   in  sample tick
//   i_busy   in  frame in progress
// -----------------------------------------------------------------------------
module mic_spi_sampler_chk (
    input logic i_clock,
    input logic i_reset,
    input logic i_tick,
    input logic i_busy
);

    // A tick must never land inside a frame.
    tick_not_busy_a : assert property (@(posedge i_clock) disable iff (i_reset) !(i_tick && i_busy));

endmodule

// File: tb/tb_mic_spi_sampler.sv
// Scoreboard bench for mic_spi_sampler. A predictor follows the tick schedule
// (every 5000 cycles after reset release) and, for every tick seen with enable
// high, picks the converter word and queues the expected frame. A converter
// model serves that word on the serial pins, and a monitor compares every cycle
// of the pins and status outputs against the expected frame timeline.
module tb_mic_spi_sampler;

    localparam int PERIOD     = 5000;
    localparam int HALF       = 25;
    localparam int CS_LOW_END = 824;   // last cycle offset with cs low
    localparam int VALID_OFS  = 850;   // offset from cs fall to valid (tick + 851)

    logic        clock  = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic        miso   = 1'b0;
    logic        cs_n;
    logic        sclk;
    logic [11:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        frame_err;

    mic_spi_sampler dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .J_MIC_Pin3   (miso),
        .J_MIC_Pin1   (cs_n),
        .J_MIC_Pin4   (sclk),
        .sample       (sample),
        .sample_valid (sample_valid),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          start_cyc;
        logic [11:0] smp;
        logic        ferr;
    } frame_t;

    typedef struct {
        logic [15:0] word;
        logic [11:0] smp;
        logic        ferr;
    } dir_t;

    frame_t      sb_q[$];
    logic [15:0] adc_q[$];
    dir_t        dir_q[$];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;
    int          fall_cnt = 0;
    int          last_valid = -1;
    int          valid_cnt = 0;
    logic [11:0] held_smp = 12'd2048;
    logic        held_ferr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Cycles since reset release; matches the tick counter value.
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Converter model: a word per cs fall, one bit per sclk falling edge, MSB first.
    initial begin
        logic [15:0] w;
        forever begin
            @(negedge cs_n);
            if (reset === 1'b0) begin
                if (adc_q.size() > 0) w = adc_q.pop_front();
                else                  w = 16'h0000;
                for (int k = 0; k < 16; k++) begin
                    @(negedge sclk or posedge cs_n);
                    if (cs_n === 1'b1) break;
                    miso = w[15 - k];
                end
            end
        end
    end

    // Predictor plus scoreboard monitor, sampled on the falling clock edge.
    always @(negedge clock) begin : monitor
        frame_t      f;
        logic [15:0] word;
        int          o;
        bit          in_frame;
        logic        e_cs;
        logic        e_sclk;
        logic        e_valid;
        if (reset === 1'b1) begin
            chk("rst_cs", cs_n, 1);
            chk("rst_sclk", sclk, 1);
            chk("rst_busy", busy, 0);
            chk("rst_sample", sample, 2048);
            chk("rst_valid", sample_valid, 0);
            chk("rst_frame_err", frame_err, 0);
            sb_q.delete();
            adc_q.delete();
            prev_cs    = 1'b1;
            prev_sclk  = 1'b1;
            fall_cnt   = 0;
            last_valid = -1;
            held_smp   = 12'd2048;
            held_ferr  = 1'b0;
        end else if (done) begin
            chk("frames_outstanding", sb_q.size(), 0);
            chk("valid_count", valid_cnt, 12);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else begin
            if ((cyc % PERIOD == PERIOD - 1) && enable === 1'b1) begin
                if (dir_q.size() > 0) begin
                    dir_t d;
                    d = dir_q.pop_front();
                    word  = d.word;
                    f.smp  = d.smp;
                    f.ferr = d.ferr;
                end else begin
                    word = 16'($urandom);
                    if ($urandom_range(1, 0) == 0) word[15:12] = 4'h0;
                    f.smp  = word[11:0];
                    f.ferr = (word[15:12] != 4'h0);
                end
                f.start_cyc = cyc + 1;
                sb_q.push_back(f);
                adc_q.push_back(word);
            end

            in_frame = 1'b0;
            o = 0;
            if (sb_q.size() > 0) begin
                o = cyc - sb_q[0].start_cyc;
                in_frame = (o >= 0) && (o <= VALID_OFS);
            end
            e_cs    = !(in_frame && o <= CS_LOW_END);
            e_sclk  = (in_frame && o >= HALF && o <= CS_LOW_END) ? (((o - HALF) / HALF) % 2 == 1) : 1'b1;
            e_valid = in_frame && (o == VALID_OFS);

            chk("cs_n", cs_n, e_cs);
            chk("sclk", sclk, e_sclk);
            chk("busy", busy, in_frame);
            chk("sample_valid", sample_valid, e_valid);

            if (e_valid) begin
                f = sb_q.pop_front();
                chk("sample", sample, f.smp);
                chk("frame_err", frame_err, f.ferr);
                held_smp  = f.smp;
                held_ferr = f.ferr;
            end else begin
                chk("sample_hold", sample, held_smp);
                chk("frame_err_hold", frame_err, held_ferr);
            end

            if (sample_valid === 1'b1) begin
                valid_cnt++;
                if (last_valid >= 0) chk("valid_period", cyc - last_valid, PERIOD);
                last_valid = cyc;
            end

            if (prev_cs === 1'b1 && cs_n === 1'b0) fall_cnt = 0;
            if (prev_sclk === 1'b1 && sclk === 1'b0 && cs_n === 1'b0) fall_cnt++;
            if (prev_cs === 1'b0 && cs_n === 1'b1) chk("sclk_falls_per_frame", fall_cnt, 16);
            prev_cs   = cs_n;
            prev_sclk = sclk;
        end
    end

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 200000) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    // Stimulus: reset, idle with enable low, free run, reset mid-frame, enable drop.
    initial begin
        dir_q.push_back('{16'h0ABC, 12'hABC, 1'b0});
        dir_q.push_back('{16'h8123, 12'h123, 1'b1});
        dir_q.push_back('{16'h0FFF, 12'hFFF, 1'b0});
        #1 reset = 1'b1;
        repeat (5) @(posedge clock);
        #1 reset = 1'b0;

        // Enable low: no activity; first frame must follow the tick at 9999.
        wait_cyc(6000);
        enable = 1'b1;

        // Ten frames, then reset during bit 7 of the eleventh.
        wait_cyc(60000 + HALF + 7 * 2 * HALF + 10);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // One clean frame, then drop enable during bit 3 of the next one.
        wait_cyc(10000 + HALF + 3 * 2 * HALF + 10);
        enable = 1'b0;

        wait_cyc(16000);
        done = 1'b1;
        repeat (20) @(posedge clock);
        $display("FAIL watchdog: monitor did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
